// File: rtl/pixel_readout_sequencer.sv
// pixel_readout_sequencer
// Frame-level sequencer in front of the pixel control stage. For every event it
// resets the pixel, integrates for a programmed time (or waits for an external
// trigger), switches the pixel to readout and walks the selected memories with
// one ADC conversion per memory. Events are counted against a programmed target.
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   START, STOP        run request (IDLE only) / end run after current event
//   TRG_MODE, TRG_IN   0 timed, 1 triggered; external trigger (synchronous)
//   INTEG_CYC          integration length in cycles (sampled in ARM)
//   EVT_TARGET         events per run, 0 = unlimited (sampled at START)
//   PIX_RESET_BUSY, PIX_END, MEM_SET_DONE, LAST_MEM   pixel control status
//   ADC_DONE           conversion-complete pulse
//   PIX_STORE, PIX_RESET, MEM_SET_CLR, MEM_SET_EN, TRG_DET, EVT_NUM_END
//                      pixel control drive
//   ADC_START          conversion request pulse
//   BUSY, ERR, EVT_CNT run status, sticky watchdog error, completed events
//   STATE_DBG          current FSM state encoding
//
// Handshakes: every request is a registered pulse or level and every response
// is a level or pulse sampled on the following edges; a response is consumed
// only in the state that waits for it and is ignored elsewhere.
module pixel_readout_sequencer #(
  parameter int EVT_W = 8,
  parameter int INT_W = 16,
  parameter int WDOG  = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             TRG_MODE,
  input  logic             TRG_IN,
  input  logic [INT_W-1:0] INTEG_CYC,
  input  logic [EVT_W-1:0] EVT_TARGET,
  input  logic             PIX_RESET_BUSY,
  input  logic             PIX_END,
  input  logic             MEM_SET_DONE,
  input  logic             LAST_MEM,
  input  logic             ADC_DONE,
  output logic             PIX_STORE,
  output logic             PIX_RESET,
  output logic             MEM_SET_CLR,
  output logic             MEM_SET_EN,
  output logic             ADC_START,
  output logic             TRG_DET,
  output logic             EVT_NUM_END,
  output logic             BUSY,
  output logic             ERR,
  output logic [EVT_W-1:0] EVT_CNT,
  output logic [3:0]       STATE_DBG
);

  localparam int WD_W = (WDOG > 1) ? $clog2(WDOG) : 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ARM     = 4'd1,
    S_RSTREQ  = 4'd2,
    S_RSTWAIT = 4'd3,
    S_INTEG   = 4'd4,
    S_TRGWAIT = 4'd5,
    S_READ    = 4'd6,
    S_CONV    = 4'd7,
    S_MSET    = 4'd8,
    S_MWAIT   = 4'd9,
    S_EVTDONE = 4'd10
  } state_t;

  state_t           state, state_nxt;
  logic             trg_mode_q, trg_mode_nxt;
  logic [EVT_W-1:0] target_q, target_nxt;
  logic [INT_W-1:0] integ_cnt, integ_nxt;
  logic [WD_W-1:0]  wd_cnt, wd_nxt;
  logic             stop_pend, stop_nxt;
  logic             pix_store_nxt, pix_reset_nxt, mem_set_clr_nxt, mem_set_en_nxt;
  logic             adc_start_nxt, trg_det_nxt, evt_num_end_nxt, err_nxt;
  logic [EVT_W-1:0] evt_cnt_nxt;
  logic [EVT_W-1:0] evt_inc;
  logic             wd_expire;
  logic             wd_trip;

  assign evt_inc   = EVT_CNT + EVT_W'(1);
  assign wd_expire = (wd_cnt == WD_W'(WDOG - 1));
  assign STATE_DBG = state;

  always_comb begin
    state_nxt       = state;
    trg_mode_nxt    = trg_mode_q;
    target_nxt      = target_q;
    integ_nxt       = integ_cnt;
    wd_nxt          = wd_cnt;
    stop_nxt        = stop_pend | STOP;
    pix_store_nxt   = PIX_STORE;
    pix_reset_nxt   = 1'b0;
    mem_set_clr_nxt = 1'b0;
    mem_set_en_nxt  = 1'b0;
    adc_start_nxt   = 1'b0;
    trg_det_nxt     = 1'b0;
    evt_num_end_nxt = EVT_NUM_END;
    err_nxt         = ERR;
    evt_cnt_nxt     = EVT_CNT;
    wd_trip         = 1'b0;

    case (state)
      S_IDLE: begin
        stop_nxt = 1'b0;
        if (START) begin
          state_nxt       = S_ARM;
          evt_cnt_nxt     = '0;
          err_nxt         = 1'b0;
          evt_num_end_nxt = 1'b0;
          trg_mode_nxt    = TRG_MODE;
          target_nxt      = EVT_TARGET;
        end
      end
      S_ARM: begin
        pix_store_nxt = 1'b1;
        integ_nxt     = INTEG_CYC;
        wd_nxt        = '0;
        state_nxt     = S_RSTREQ;
      end
      S_RSTREQ: begin
        // In triggered mode the PIX_STORE rising edge already starts the reset.
        if (PIX_RESET_BUSY) begin
          state_nxt = S_RSTWAIT;
        end else if (wd_expire) begin
          wd_trip = 1'b1;
        end else begin
          pix_reset_nxt = ~trg_mode_q;
          wd_nxt        = wd_cnt + WD_W'(1);
        end
      end
      S_RSTWAIT: begin
        if (PIX_END) begin
          state_nxt = trg_mode_q ? S_TRGWAIT : S_INTEG;
        end else if (wd_expire) begin
          wd_trip = 1'b1;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
        end
      end
      S_INTEG: begin
        if (integ_cnt == '0) begin
          state_nxt       = S_READ;
          pix_store_nxt   = 1'b0;
          mem_set_clr_nxt = 1'b1;
        end else begin
          integ_nxt = integ_cnt - INT_W'(1);
        end
      end
      S_TRGWAIT: begin
        // No event is in flight yet, so a stop ends the run immediately.
        if (STOP || stop_pend) begin
          state_nxt     = S_IDLE;
          pix_store_nxt = 1'b0;
        end else if (TRG_IN) begin
          state_nxt       = S_READ;
          trg_det_nxt     = 1'b1;
          pix_store_nxt   = 1'b0;
          mem_set_clr_nxt = 1'b1;
        end
      end
      S_READ: begin
        state_nxt     = S_CONV;
        adc_start_nxt = 1'b1;
      end
      S_CONV: begin
        // ADC_DONE is not accepted while ADC_START is still high; this also
        // keeps at least three low cycles between MEM_SET_EN pulses.
        if (ADC_DONE && !ADC_START) begin
          if (LAST_MEM) begin
            state_nxt = S_EVTDONE;
          end else begin
            state_nxt      = S_MSET;
            mem_set_en_nxt = 1'b1;
          end
        end
      end
      S_MSET: begin
        state_nxt = S_MWAIT;
      end
      S_MWAIT: begin
        if (MEM_SET_DONE) begin
          state_nxt     = S_CONV;
          adc_start_nxt = 1'b1;
        end else if (wd_expire) begin
          wd_trip = 1'b1;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
        end
      end
      S_EVTDONE: begin
        evt_cnt_nxt = evt_inc;
        if ((target_q != '0) && (evt_inc == target_q)) begin
          evt_num_end_nxt = 1'b1;
          state_nxt       = S_IDLE;
        end else if (stop_pend || STOP) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_ARM;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (wd_trip) begin
      err_nxt       = 1'b1;
      pix_store_nxt = 1'b0;
      state_nxt     = S_IDLE;
    end

    // Each waiting state gets a fresh watchdog window.
    if (state_nxt != state) wd_nxt = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      trg_mode_q  <= 1'b0;
      target_q    <= '0;
      integ_cnt   <= '0;
      wd_cnt      <= '0;
      stop_pend   <= 1'b0;
      PIX_STORE   <= 1'b0;
      PIX_RESET   <= 1'b0;
      MEM_SET_CLR <= 1'b0;
      MEM_SET_EN  <= 1'b0;
      ADC_START   <= 1'b0;
      TRG_DET     <= 1'b0;
      EVT_NUM_END <= 1'b0;
      BUSY        <= 1'b0;
      ERR         <= 1'b0;
      EVT_CNT     <= '0;
    end else begin
      state       <= state_nxt;
      trg_mode_q  <= trg_mode_nxt;
      target_q    <= target_nxt;
      integ_cnt   <= integ_nxt;
      wd_cnt      <= wd_nxt;
      stop_pend   <= stop_nxt;
      PIX_STORE   <= pix_store_nxt;
      PIX_RESET   <= pix_reset_nxt;
      MEM_SET_CLR <= mem_set_clr_nxt;
      MEM_SET_EN  <= mem_set_en_nxt;
      ADC_START   <= adc_start_nxt;
      TRG_DET     <= trg_det_nxt;
      EVT_NUM_END <= evt_num_end_nxt;
      BUSY        <= (state_nxt != S_IDLE);
      ERR         <= err_nxt;
      EVT_CNT     <= evt_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pixel_readout_sequencer.sv
`timescale 1ns/1ps
module tb_pixel_readout_sequencer;

  localparam int WD = 20;

  // State encodings as seen on STATE_DBG
  localparam logic [3:0] S_IDLE = 4'd0, S_ARM = 4'd1, S_RSTREQ = 4'd2, S_RSTWAIT = 4'd3;
  localparam logic [3:0] S_INTEG = 4'd4, S_TRGWAIT = 4'd5, S_READ = 4'd6, S_CONV = 4'd7;
  localparam logic [3:0] S_MWAIT = 4'd9, S_EVTDONE = 4'd10;

  // Pulse trace codes
  localparam logic [3:0] C_PRST = 4'd1, C_TRG = 4'd2, C_CLR = 4'd3, C_ADC = 4'd4, C_MSE = 4'd5;

  logic        CLK, RST, START, STOP, TRG_MODE, TRG_IN;
  logic [15:0] INTEG_CYC;
  logic [7:0]  EVT_TARGET;
  logic        PIX_RESET_BUSY, PIX_END, MEM_SET_DONE, LAST_MEM, ADC_DONE;
  logic        PIX_STORE, PIX_RESET, MEM_SET_CLR, MEM_SET_EN, ADC_START, TRG_DET;
  logic        EVT_NUM_END, BUSY, ERR;
  logic [7:0]  EVT_CNT;
  logic [3:0]  STATE_DBG;

  pixel_readout_sequencer #(.EVT_W(8), .INT_W(16), .WDOG(WD)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .TRG_MODE(TRG_MODE),
    .TRG_IN(TRG_IN), .INTEG_CYC(INTEG_CYC), .EVT_TARGET(EVT_TARGET),
    .PIX_RESET_BUSY(PIX_RESET_BUSY), .PIX_END(PIX_END), .MEM_SET_DONE(MEM_SET_DONE),
    .LAST_MEM(LAST_MEM), .ADC_DONE(ADC_DONE), .PIX_STORE(PIX_STORE),
    .PIX_RESET(PIX_RESET), .MEM_SET_CLR(MEM_SET_CLR), .MEM_SET_EN(MEM_SET_EN),
    .ADC_START(ADC_START), .TRG_DET(TRG_DET), .EVT_NUM_END(EVT_NUM_END),
    .BUSY(BUSY), .ERR(ERR), .EVT_CNT(EVT_CNT), .STATE_DBG(STATE_DBG)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #20 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] act_q[$];
  logic       mon_en = 1'b0;
  logic       prst_q = 1'b0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (PIX_RESET && !prst_q) act_q.push_back(C_PRST);
      if (TRG_DET)     act_q.push_back(C_TRG);
      if (MEM_SET_CLR) act_q.push_back(C_CLR);
      if (ADC_START)   act_q.push_back(C_ADC);
      if (MEM_SET_EN)  act_q.push_back(C_MSE);
    end
    prst_q <= PIX_RESET;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic sb_compare(input string name);
    int n;
    chk({name, "_trace_len"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_trace_item"}, act_q[i], exp_q[i]);
  endtask

  function automatic logic [16:0] outs();
    return {PIX_STORE, PIX_RESET, MEM_SET_CLR, MEM_SET_EN, ADC_START, TRG_DET,
            EVT_NUM_END, BUSY, ERR, EVT_CNT};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Plays pixel control and ADC for one event. Entry: just after the edge into ARM.
  task automatic run_event(input logic mode, input int integ, input int mems,
                           input logic do_stop, input logic to_mwait);
    int k;
    tick();
    chk("arm_store", PIX_STORE, 1);
    tick();
    chk("rst_req_level", PIX_RESET, !mode);
    if (!mode) exp_q.push_back(C_PRST);
    PIX_RESET_BUSY = 1'b1;
    tick();
    chk("rst_drop", PIX_RESET, 0);
    chk("st_rstwait", STATE_DBG, S_RSTWAIT);
    PIX_RESET_BUSY = 1'b0;
    TRG_IN = mode;            // trigger outside TRGWAIT must be ignored
    tick();
    TRG_IN = 1'b0;
    tick();
    PIX_END = 1'b1;
    tick();
    PIX_END = 1'b0;
    chk("st_after_end", STATE_DBG, mode ? S_TRGWAIT : S_INTEG);
    if (!mode) begin
      k = 0;
      while (PIX_STORE === 1'b1 && k < integ + 8) begin
        tick();
        k++;
      end
      chk("store_fall_cycles", k, integ + 1);
    end else begin
      repeat (39) tick();
      chk("store_hold", PIX_STORE, 1);
      TRG_IN = 1'b1;
      tick();
      TRG_IN = 1'b0;
      chk("trg_det", TRG_DET, 1);
      chk("trg_store_low", PIX_STORE, 0);
      exp_q.push_back(C_TRG);
    end
    chk("mem_set_clr", MEM_SET_CLR, 1);
    exp_q.push_back(C_CLR);
    tick();
    chk("adc_start_first", ADC_START, 1);
    exp_q.push_back(C_ADC);
    for (int m = 0; m < mems; m++) begin
      tick();
      tick();
      ADC_DONE = 1'b1;
      LAST_MEM = (m == mems - 1);
      STOP     = do_stop && (m == 0);
      tick();
      ADC_DONE = 1'b0;
      LAST_MEM = 1'b0;
      STOP     = 1'b0;
      if (m == mems - 1) begin
        chk("st_evtdone", STATE_DBG, S_EVTDONE);
      end else begin
        chk("mem_set_en", MEM_SET_EN, 1);
        exp_q.push_back(C_MSE);
        tick();
        if (to_mwait) return;
        tick();
        MEM_SET_DONE = 1'b1;
        tick();
        MEM_SET_DONE = 1'b0;
        chk("adc_start_next", ADC_START, 1);
        exp_q.push_back(C_ADC);
      end
    end
    tick();
  endtask

  task automatic do_start(input logic mode, input int integ, input logic [7:0] target);
    TRG_MODE   = mode;
    INTEG_CYC  = 16'(integ);
    EVT_TARGET = target;
    START      = 1'b1;
    tick();
    START      = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       mode;
    int         integ;
    logic [7:0] target;
    int         mems;
    int         stop_ev;
    int         n_ev;
    logic       exp_end;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v);
    exp_q.delete();
    act_q.delete();
    mon_en = 1'b1;
    do_start(v.mode, v.integ, v.target);
    chk("start_busy", BUSY, 1);
    chk("start_arm", STATE_DBG, S_ARM);
    chk("start_cnt_clear", EVT_CNT, 0);
    chk("start_end_clear", EVT_NUM_END, 0);
    TRG_MODE   = ~v.mode;     // both are latched at START
    EVT_TARGET = 8'hFF;
    for (int e = 0; e < v.n_ev; e++) begin
      run_event(v.mode, v.integ, v.mems, (v.stop_ev == e), 1'b0);
      chk("evt_cnt_step", EVT_CNT, 32'(e + 1));
      chk("after_evtdone", STATE_DBG, (e == v.n_ev - 1) ? S_IDLE : S_ARM);
    end
    chk("run_end_busy", BUSY, 0);
    chk("run_num_end", EVT_NUM_END, v.exp_end);
    chk("run_final_cnt", EVT_CNT, v.exp_cnt);
    repeat (3) tick();
    mon_en = 1'b0;
    sb_compare("run");
  endtask

  // ---------------- test ----------------
  int k;

  initial begin
    //        mode  integ target mems stop n_ev end  cnt
    vecs[0] = '{1'b0, 5, 8'd1, 2, -1, 1, 1'b1, 8'd1};
    vecs[1] = '{1'b1, 7, 8'd3, 1, -1, 3, 1'b1, 8'd3};
    vecs[2] = '{1'b0, 2, 8'd0, 3,  1, 2, 1'b0, 8'd2};
    vecs[3] = '{1'b0, 0, 8'd2, 1, -1, 2, 1'b1, 8'd2};
    vecs[4] = '{1'b0, 3, 8'd5, 2,  0, 1, 1'b0, 8'd1};

    RST = 1'b1; START = 1'b0; STOP = 1'b0; TRG_MODE = 1'b0; TRG_IN = 1'b0;
    INTEG_CYC = '0; EVT_TARGET = '0; PIX_RESET_BUSY = 1'b0; PIX_END = 1'b0;
    MEM_SET_DONE = 1'b0; LAST_MEM = 1'b0; ADC_DONE = 1'b0;
    repeat (3) tick();
    chk("reset_outs", outs(), 0);
    RST = 1'b0;
    tick();
    chk("idle_outs", outs(), 0);
    chk("idle_state", STATE_DBG, S_IDLE);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Watchdog in RSTWAIT: PIX_END never arrives
    do_start(1'b0, 3, 8'd1);
    tick();
    PIX_RESET_BUSY = 1'b1;
    tick();
    PIX_RESET_BUSY = 1'b0;
    chk("wd_in_rstwait", STATE_DBG, S_RSTWAIT);
    k = 0;
    while (ERR !== 1'b1 && k < WD + 10) begin
      tick();
      k++;
    end
    chk("wd_rstwait_cycles", k, WD);
    chk("wd_store_low", PIX_STORE, 0);
    chk("wd_busy_low", BUSY, 0);
    chk("wd_idle", STATE_DBG, S_IDLE);
    do_start(1'b0, 3, 8'd1);
    chk("err_cleared_by_start", ERR, 0);
    chk("restart_busy", BUSY, 1);
    // Watchdog in RSTREQ: PIX_RESET_BUSY never arrives
    tick();
    k = 0;
    while (ERR !== 1'b1 && k < WD + 10) begin
      tick();
      k++;
    end
    chk("wd_rstreq_cycles", k, WD);
    chk("wd_rstreq_reset_low", PIX_RESET, 0);
    chk("wd_rstreq_busy", BUSY, 0);

    // START while busy, INTEG_CYC=0, RST mid-CONV
    do_start(1'b0, 0, 8'd0);
    tick();
    PIX_RESET_BUSY = 1'b1;
    tick();
    PIX_RESET_BUSY = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("start_ignored_busy", STATE_DBG, S_RSTWAIT);
    PIX_END = 1'b1;
    tick();
    PIX_END = 1'b0;
    chk("integ0_enter", STATE_DBG, S_INTEG);
    tick();
    chk("integ0_one_cycle", STATE_DBG, S_READ);
    tick();
    chk("conv_reached", STATE_DBG, S_CONV);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("start_ignored_conv", STATE_DBG, S_CONV);
    RST = 1'b1;
    tick();
    chk("rst_conv_outs", outs(), 0);
    chk("rst_conv_idle", STATE_DBG, S_IDLE);
    RST = 1'b0;
    tick();

    // RST mid-MWAIT during the second event
    do_start(1'b0, 1, 8'd0);
    run_event(1'b0, 1, 2, 1'b0, 1'b0);
    chk("mwait_prev_cnt", EVT_CNT, 1);
    run_event(1'b0, 1, 2, 1'b0, 1'b1);
    chk("mwait_reached", STATE_DBG, S_MWAIT);
    RST = 1'b1;
    tick();
    chk("rst_mwait_outs", outs(), 0);
    chk("rst_mwait_idle", STATE_DBG, S_IDLE);
    RST = 1'b0;
    tick();

    // Triggered mode, STOP while waiting for the trigger
    do_start(1'b1, 0, 8'd0);
    tick();
    PIX_RESET_BUSY = 1'b1;
    tick();
    PIX_RESET_BUSY = 1'b0;
    PIX_END = 1'b1;
    tick();
    PIX_END = 1'b0;
    chk("trgwait_reached", STATE_DBG, S_TRGWAIT);
    tick();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("trgstop_idle", STATE_DBG, S_IDLE);
    chk("trgstop_busy", BUSY, 0);
    chk("trgstop_store", PIX_STORE, 0);
    chk("trgstop_cnt", EVT_CNT, 0);
    TRG_IN = 1'b1;
    tick();
    TRG_IN = 1'b0;
    chk("trg_ignored_idle", TRG_DET, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_readout_sequencer.md
# pixel_readout_sequencer

Frame-level sequencer that sits directly upstream of the pixel control stage and drives its `PIX_STORE`, `PIX_RESET`, `MEM_SET_EN`, `MEM_SET_CLR`, `TRG_DET` and `EVT_NUM_END` inputs. For each event it:
- runs pixel reset;
- integrates for a programmed time, or waits for an external trigger;
- switches the pixel to readout;
- steps through every selected memory, issuing one ADC conversion handshake per memory.

It counts events and stops at a programmed target, or on request.

## Interface
- `EVT_W`, default 8: width of the event counter and target.
- `INT_W`, default 16: width of the integration counter.
- `WDOG`, default 255: watchdog limit in cycles for pixel-control responses.

Ports:
- `CLK` in 1: system clock, 25 MHz. One clock domain.
- `RST` in 1: reset, synchronous, active-high.
- `START` in 1: 1-cycle run request. Ignored unless in IDLE.
- `STOP` in 1: 1-cycle request; the run ends after the current event.
- `TRG_MODE` in 1: 0 selects timed integration, 1 selects triggered. Sampled at START.
- `TRG_IN` in 1: external trigger, already synchronous to `CLK`.
- `INTEG_CYC` in `INT_W`: integration length in cycles. Sampled at ARM.
- `EVT_TARGET` in `EVT_W`: events per run; 0 means unlimited. Sampled at START.
- `PIX_RESET_BUSY` in 1: from pixel control.
- `PIX_END` in 1: from pixel control.
- `MEM_SET_DONE` in 1: from pixel control.
- `LAST_MEM` in 1: from pixel control.
- `ADC_DONE` in 1: 1-cycle conversion-complete pulse from the ADC interface.
- `PIX_STORE` out 1: store level to pixel control.
- `PIX_RESET` out 1: reset request to pixel control.
- `MEM_SET_CLR` out 1: 1-cycle pulse.
- `MEM_SET_EN` out 1: 1-cycle pulse.
- `ADC_START` out 1: 1-cycle conversion request.
- `TRG_DET` out 1: 1-cycle pulse when a trigger is accepted.
- `EVT_NUM_END` out 1: level; high when the target is reached.
- `BUSY` out 1: high in every state except IDLE.
- `ERR` out 1: sticky watchdog error.
- `EVT_CNT` out `EVT_W`: events completed in the current run.

## Operation
- All outputs are registered.
- Reset value of every output is 0. State after reset is IDLE.
- `RST` during any state returns the block to IDLE with all outputs at 0 on the next edge.

State machine:
- **IDLE**
  - `START` → ARM.
  - On the same edge: `EVT_CNT`←0, `ERR`←0, `EVT_NUM_END`←0, latch `TRG_MODE` and `EVT_TARGET`.
- **ARM** (1 cycle)
  - `PIX_STORE`←1, load the integration counter with `INTEG_CYC`, clear the watchdog → RSTREQ.
- **RSTREQ**
  - Timed mode: `PIX_RESET`=1 until `PIX_RESET_BUSY`=1 is seen, then `PIX_RESET`←0 → RSTWAIT.
  - Triggered mode: `PIX_RESET` stays 0, because the rising edge of `PIX_STORE` starts the reset in pixel control. Wait for `PIX_RESET_BUSY`=1 → RSTWAIT.
- **RSTWAIT**
  - `PIX_END`=1 → INTEG in timed mode, TRGWAIT in triggered mode.
- **INTEG**
  - Counter 0 → READ; otherwise decrement.
  - `INTEG_CYC`=0 stays exactly 1 cycle in INTEG.
- **TRGWAIT**
  - `TRG_IN`=1 → `TRG_DET` pulse (1 cycle) → READ.
  - `STOP` here → IDLE with `PIX_STORE`←0. `EVT_CNT` is not incremented.
- **READ** (1 cycle)
  - `PIX_STORE`←0, `MEM_SET_CLR` pulse → CONV.
- **CONV**
  - `ADC_START` pulse on entry, then wait for `ADC_DONE`.
  - On `ADC_DONE`: `LAST_MEM`=1 → EVTDONE, else → MSET.
- **MSET** (1 cycle)
  - `MEM_SET_EN` pulse → MWAIT.
- **MWAIT**
  - `MEM_SET_DONE`=1 → CONV.
- **EVTDONE** (1 cycle)
  - `EVT_CNT`+1.
  - If `EVT_TARGET`≠0 and the new count equals `EVT_TARGET`: `EVT_NUM_END`←1 → IDLE.
  - Else if a stop is pending → IDLE.
  - Else → ARM.
- **Watchdog**
  - In RSTREQ, RSTWAIT and MWAIT, waiting `WDOG` cycles without the expected input → `ERR`←1, all pulse outputs 0, `PIX_STORE`←0 → IDLE.
  - CONV has no watchdog.

Rules:
- `STOP` is latched into a pending flag in any non-IDLE state. The flag is cleared in IDLE.
- `START` while BUSY is ignored.
- `EVT_CNT` wraps at 2^`EVT_W` when `EVT_TARGET`=0. `EVT_NUM_END` is never set in that case.
- `EVT_NUM_END` holds until the next accepted `START` or `RST`.

## Timing
- `START` at edge n: `BUSY`=1 and state ARM after n. `PIX_STORE`=1 after n+1. In timed mode `PIX_RESET`=1 from n+2.
- `PIX_RESET` drops on the edge after `PIX_RESET_BUSY` is first sampled high.
- Timed mode: the first INTEG cycle follows the edge that samples `PIX_END`. `PIX_STORE` falls `INTEG_CYC`+1 cycles after INTEG entry, together with the `MEM_SET_CLR` pulse.
- `ADC_START` is asserted the cycle after the `MEM_SET_CLR` pulse, and the cycle after `MEM_SET_DONE` is sampled.
- `MEM_SET_EN` pulses are always separated by at least 3 low cycles, so pixel control detects each rising edge.
- `TRG_DET` is high in the cycle after `TRG_IN` is sampled. `TRG_IN` outside TRGWAIT is ignored.
- `ADC_DONE` and `STOP` arriving on the same edge: the conversion completes normally, and the stop takes effect at EVTDONE.

## Test plan
- Timed mode, `INTEG_CYC`=5, `EVT_TARGET`=1, memory chain LAST_MEM on the 2nd memory → one `PIX_RESET` burst, `PIX_STORE` low 6 cycles after `PIX_END`, then `MEM_SET_CLR`, 2 `ADC_START`, 1 `MEM_SET_EN`. Ends with `EVT_CNT`=1, `EVT_NUM_END`=1, `BUSY`=0.
- Triggered mode, `EVT_TARGET`=3, `TRG_IN` pulsed 40 cycles after each `PIX_END` → `PIX_RESET` never asserted, 3 `TRG_DET` pulses. Ends with `EVT_CNT`=3, `EVT_NUM_END`=1.
- `EVT_TARGET`=0, `STOP` pulsed during the 2nd event's CONV → run ends after EVTDONE with `EVT_CNT`=2 and `EVT_NUM_END`=0.
- `PIX_END` held low after reset begins → `ERR`=1 exactly `WDOG` cycles after RSTWAIT entry, `PIX_STORE`=0, `BUSY`=0. A following `START` clears `ERR`.
- `INTEG_CYC`=0 → exactly one INTEG cycle. `START` pulsed while BUSY → no effect.
- `RST` asserted mid-CONV and mid-MWAIT → all outputs 0 on the next edge, IDLE, `EVT_CNT`=0.
